rr_priority_arb: RTL and testbench

Parametrised round-robin arbiter with a registered rotating bottom pointer and a valid/ready grant port. It picks the first asserted request at or above the bottom pointer, wrapping modulo N. It optionally locks the grant until it is accepted, then advances the pointer past the winner. It sits in front of shared issue/refill/writeback resources wherever N requesters contend for one slot per cycle.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 38 +++
 rtl/rr_priority_arb.sv | 113 +++++++++++
 tb/tb_rr_priority_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and index helpers for the round-robin priority arbiter.
// Pointer arithmetic wraps by compare so any requester count works.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

  function automatic int unsigned ptr_clamp(input int unsigned val, input int unsigned n);
    return (val >= n) ? 0 : val;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search: first set request at or above
// bottom, wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 16,
  localparam int unsigned PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] bottom,
  output logic             valid,
  output logic [PTR_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_p;
    logic             found;
    valid  = |req;
    idx    = '0;
    onehot = '0;
    found  = 1'b0;
    cand   = 32'(bottom);
    for (int unsigned k = 0; k < N; k++) begin
      cand_p = PTR_W'(cand);
      if (!found && req[cand_p]) begin
        found = 1'b1;
        idx   = cand_p;
      end
      cand = wrap_inc(cand, N);
    end
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_priority_arb.sv
// Round-robin arbiter with registered bottom pointer, optional grant lock
// and valid/ready grant handshake.
module rr_priority_arb
  import arb_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter bit          LOCK = 1'b1,
  localparam int unsigned PTR_W = ptr_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N-1:0]     req_i,
  input  logic             grant_ready_i,
  input  logic             flush_i,
  input  logic             ptr_load_i,
  input  logic [PTR_W-1:0] ptr_load_val_i,
  output logic             grant_valid_o,
  output logic [PTR_W-1:0] grant_ptr_o,
  output logic [N-1:0]     grant_onehot_o,
  output logic [PTR_W-1:0] bottom_ptr_o
);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] bottom_q, bottom_d;
  logic [PTR_W-1:0] held_q, held_d;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;

  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic [N-1:0]     grant_onehot;
  logic             handshake;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req   (req_i),
    .bottom(bottom_q),
    .valid (pick_valid),
    .idx   (pick_idx),
    .onehot(pick_onehot)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      bottom_q <= '0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      bottom_q <= bottom_d;
      held_q   <= held_d;
    end
  end

  // Outputs are gated by reset so nothing is presented while it is asserted.
  always_comb begin
    grant_idx    = pick_idx;
    grant_valid  = pick_valid;
    grant_onehot = pick_onehot;
    if (state_q == HOLD) begin
      grant_idx    = held_q;
      grant_valid  = 1'b1;
      grant_onehot = N'(1) << held_q;
    end
    if (!rst_n_i) begin
      grant_idx   = '0;
      grant_valid = 1'b0;
    end
    if (flush_i) begin
      grant_valid = 1'b0;
    end
    handshake      = grant_valid & grant_ready_i;
    grant_valid_o  = grant_valid;
    grant_ptr_o    = grant_idx;
    grant_onehot_o = grant_valid ? grant_onehot : '0;
    bottom_ptr_o   = bottom_q;
  end

  // A pointer load overrides the handshake advance but the handshake still
  // retires the held grant.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    bottom_d = bottom_q;
    if (flush_i || handshake) begin
      state_d = IDLE;
    end else if (LOCK && (state_q == IDLE) && grant_valid && !grant_ready_i) begin
      state_d = HOLD;
      held_d  = grant_idx;
    end
    if (ptr_load_i) begin
      bottom_d = PTR_W'(ptr_clamp(32'(ptr_load_val_i), N));
    end else if (handshake) begin
      bottom_d = PTR_W'(wrap_inc(32'(grant_idx), N));
    end
  end

  onehot_matches_ptr : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    grant_valid_o |-> (grant_onehot_o == (N'(1) << grant_ptr_o)));

  onehot_zero_when_idle : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !grant_valid_o |-> (grant_onehot_o == '0));

  hold_is_stable : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ((state_q == HOLD) && !handshake && !flush_i) |=> (grant_ptr_o == $past(grant_ptr_o)));

  no_hold_without_lock : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !LOCK |-> (state_q == IDLE));

endmodule

// File: tb/tb_rr_priority_arb.sv
// Randomised scoreboard bench for rr_priority_arb: N=16 locked, N=5 locked
// and N=16 unlocked instances share one stimulus stream.
module tb_rr_priority_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] req;
  logic        ready, flush, load;
  logic [3:0]  lval;

  logic        a_v, b_v, c_v;
  logic [3:0]  a_p, a_b, c_p, c_b;
  logic [2:0]  b_p, b_b;
  logic [15:0] a_oh, c_oh;
  logic [4:0]  b_oh;

  rr_priority_arb #(.N(16), .LOCK(1'b1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .grant_ready_i(ready), .flush_i(flush),
    .ptr_load_i(load), .ptr_load_val_i(lval), .grant_valid_o(a_v), .grant_ptr_o(a_p),
    .grant_onehot_o(a_oh), .bottom_ptr_o(a_b)
  );

  rr_priority_arb #(.N(5), .LOCK(1'b1)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[4:0]), .grant_ready_i(ready), .flush_i(flush),
    .ptr_load_i(load), .ptr_load_val_i(lval[2:0]), .grant_valid_o(b_v), .grant_ptr_o(b_p),
    .grant_onehot_o(b_oh), .bottom_ptr_o(b_b)
  );

  rr_priority_arb #(.N(16), .LOCK(1'b0)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .grant_ready_i(ready), .flush_i(flush),
    .ptr_load_i(load), .ptr_load_val_i(lval), .grant_valid_o(c_v), .grant_ptr_o(c_p),
    .grant_onehot_o(c_oh), .bottom_ptr_o(c_b)
  );

  typedef struct {
    logic        v;
    logic [31:0] p;
    logic [31:0] b;
    logic [31:0] oh;
  } obs_t;

  typedef struct {
    int bot;
    bit hold;
    int held;
  } mst_t;

  obs_t sb[3][$];
  mst_t ms[3];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference: rotate-and-scan with modulo, lock by remembering the presented winner.
  function automatic void model(input int n, input bit lock, input mst_t s, input bit rst,
                                input int rq, input bit rdy, input bit fl, input bit ld,
                                input int lv, output obs_t o, output mst_t ns);
    int win;
    bit hs;
    ns = s;
    o  = '{1'b0, 32'd0, 32'd0, 32'd0};
    if (!rst) begin
      ns = '{0, 1'b0, 0};
      return;
    end
    win = -1;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (s.bot + k) % n;
      if (win < 0 && rq[i]) win = i;
    end
    if (s.hold) begin
      o.v = 1'b1;
      o.p = s.held;
    end else begin
      o.v = (win >= 0);
      o.p = (win >= 0) ? win : 0;
    end
    if (fl) o.v = 1'b0;
    o.b  = s.bot;
    o.oh = o.v ? (32'd1 << o.p) : 32'd0;
    hs   = o.v && rdy;
    if (fl || hs) ns.hold = 1'b0;
    else if (lock && !s.hold && o.v && !rdy) begin
      ns.hold = 1'b1;
      ns.held = int'(o.p);
    end
    if (ld) ns.bot = (lv >= n) ? 0 : lv;
    else if (hs) ns.bot = (int'(o.p) + 1) % n;
  endfunction

  task automatic step();
    obs_t o;
    mst_t ns;
    model(16, 1'b1, ms[0], rst_n, int'(req), ready, flush, load, int'(lval), o, ns);
    sb[0].push_back(o);
    ms[0] = ns;
    model(5, 1'b1, ms[1], rst_n, int'(req[4:0]), ready, flush, load, int'(lval[2:0]), o, ns);
    sb[1].push_back(o);
    ms[1] = ns;
    model(16, 1'b0, ms[2], rst_n, int'(req), ready, flush, load, int'(lval), o, ns);
    sb[2].push_back(o);
    ms[2] = ns;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] r, input logic rdy, input logic fl, input logic ld,
                       input logic [3:0] lv);
    req   = r;
    ready = rdy;
    flush = fl;
    load  = ld;
    lval  = lv;
    step();
  endtask

  function automatic obs_t actual(input int g);
    obs_t a;
    case (g)
      0:       a = '{a_v, 32'(a_p), 32'(a_b), 32'(a_oh)};
      1:       a = '{b_v, 32'(b_p), 32'(b_b), 32'(b_oh)};
      default: a = '{c_v, 32'(c_p), 32'(c_b), 32'(c_oh)};
    endcase
    return a;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin
      obs_t e, a;
      int   n;
      n = 0;
      forever begin
        @(negedge clk);
        #2;
        if (sb[g].size() > 0) begin
          e = sb[g].pop_front();
          a = actual(g);
          checks++;
          if (a.v !== e.v || a.p !== e.p || a.b !== e.b || a.oh !== e.oh) begin
            failures++;
            $display("FAIL dut%0d obs%0d: got v=%b ptr=%0d bot=%0d oh=%h, want v=%b ptr=%0d bot=%0d oh=%h",
                     g, n, a.v, a.p, a.b, a.oh, e.v, e.p, e.b, e.oh);
          end
          n++;
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) ms[d] = '{0, 1'b0, 0};
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    flush = 1'b0;
    load  = 1'b0;
    lval  = '0;
    @(negedge clk);
    repeat (2) drive(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;

    // Hold across request changes, then accept; then flush while held.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd14);
    drive(16'h0003, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (3) drive(16'h0002, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0002, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd14);
    drive(16'h0003, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0003, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // Load coinciding with a handshake out of HOLD.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd3);
    drive(16'h0008, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0008, 1'b1, 1'b0, 1'b1, 4'd9);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // Wrap and out-of-range loads on the N=5 instance.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd4);
    drive(16'h0003, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(16'h0010, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd3);
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 4'd6);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // Unaccepted grant moving with requests when unlocked.
    drive(16'h0010, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0020, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(16'h0020, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset while holding, then full-request fairness sweep.
    rst_n = 1'b0;
    repeat (2) drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    repeat (17) drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0);

    repeat (3000) begin
      logic [15:0] r;
      case ($urandom_range(3))
        0:       r = 16'($urandom);
        1:       r = 16'(1) << $urandom_range(15);
        2:       r = 16'($urandom) & 16'($urandom);
        default: r = '0;
      endcase
      rst_n = ($urandom_range(99) != 0);
      drive(r, 1'($urandom_range(1)), ($urandom_range(9) == 0), ($urandom_range(9) == 0),
            4'($urandom));
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        failures++;
        $display("FAIL dut%0d drain: got %0d pending, want 0", d, sb[d].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
